// File: rtl/autocorrelation_ctrl.sv
// Autocorrelation sequencer: walks lags 0..ORDER over one stored frame and
// streams x[n], x[n-k] into an external MAC. It clears the accumulator
// before each lag and captures R[k] once the last product has been summed.
module autocorrelation_ctrl #(
  parameter int FRAME_LEN = 240,
  parameter int ORDER     = 10,
  parameter int ADDR_W    = 8,
  parameter int LAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        rd_addr_a,
  output logic [ADDR_W-1:0]        rd_addr_b,
  output logic                     rd_en,
  input  logic signed [15:0]       rd_data_a,
  input  logic signed [15:0]       rd_data_b,
  output logic                     mac_clear,
  output logic signed [15:0]       mac_x,
  output logic signed [15:0]       mac_x_lag,
  input  logic signed [31:0]       mac_y,
  output logic signed [31:0]       r_data,
  output logic [LAG_W-1:0]         r_lag,
  output logic                     r_valid
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_FINISH} state_e;

  localparam logic [ADDR_W-1:0] LAST_N  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [LAG_W-1:0]  LAST_K  = LAG_W'(ORDER);

  state_e                    state_q, state_d;
  logic [LAG_W-1:0]          k_q, k_d;
  logic [ADDR_W-1:0]         n_q, n_d;
  // vld_pipe_q[1]: read data present on rd_data_*; [2]: operands on mac_x*
  logic [2:1]                vld_pipe_q, vld_pipe_d;
  logic signed [15:0]        mac_x_q, mac_x_d, mac_x_lag_q, mac_x_lag_d;
  logic signed [31:0]        r_data_q, r_data_d;
  logic [LAG_W-1:0]          r_lag_q, r_lag_d;
  logic                      r_valid_q, r_valid_d;
  logic                      done_q, done_d;
  logic                      drain_last;

  // Decoded outputs straight from the state register
  always_comb begin
    busy      = (state_q != S_IDLE);
    rd_en     = (state_q == S_ISSUE);
    rd_addr_a = rd_en ? n_q : '0;
    rd_addr_b = rd_en ? (n_q - ADDR_W'(k_q)) : '0;
    mac_clear = !((state_q == S_ISSUE) || (state_q == S_DRAIN));
    // Second drain cycle: final read has left stage 1, its operands sit on mac_x*
    drain_last = (state_q == S_DRAIN) && vld_pipe_q[2] && !vld_pipe_q[1];
  end

  // Next-state, counters, operand pipeline and result capture
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    vld_pipe_d  = {vld_pipe_q[1], rd_en};
    mac_x_d     = vld_pipe_q[1] ? rd_data_a : 16'sd0;
    mac_x_lag_d = vld_pipe_q[1] ? rd_data_b : 16'sd0;
    r_data_d    = r_data_q;
    r_lag_d     = r_lag_q;
    r_valid_d   = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        n_d     = ADDR_W'(k_q);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        n_d = n_q + ADDR_W'(1);
        if (n_q == LAST_N) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) begin
          r_data_d  = mac_y;
          r_lag_d   = k_q;
          r_valid_d = 1'b1;
          if (k_q == LAST_K) begin
            state_d = S_FINISH;
          end else begin
            k_d     = k_q + LAG_W'(1);
            state_d = S_CLEAR;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything except a capture already happening this edge
    if (busy && abort) begin
      state_d     = S_IDLE;
      vld_pipe_d  = '0;
      mac_x_d     = 16'sd0;
      mac_x_lag_d = 16'sd0;
      done_d      = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      n_q         <= '0;
      vld_pipe_q  <= '0;
      mac_x_q     <= '0;
      mac_x_lag_q <= '0;
      r_data_q    <= '0;
      r_lag_q     <= '0;
      r_valid_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      vld_pipe_q  <= vld_pipe_d;
      mac_x_q     <= mac_x_d;
      mac_x_lag_q <= mac_x_lag_d;
      r_data_q    <= r_data_d;
      r_lag_q     <= r_lag_d;
      r_valid_q   <= r_valid_d;
      done_q      <= done_d;
    end
  end

  assign mac_x     = mac_x_q;
  assign mac_x_lag = mac_x_lag_q;
  assign r_data    = r_data_q;
  assign r_lag     = r_lag_q;
  assign r_valid   = r_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_autocorrelation_ctrl.sv
// Bench for autocorrelation_ctrl with a small frame (N=8, P=2). A frame
// buffer and MAC are modelled around the DUT; a cycle-indexed reference
// derived from the lag schedule is compared on every falling edge.
module tb_autocorrelation_ctrl;
  localparam int N  = 8;
  localparam int P  = 2;
  localparam int AW = 4;
  localparam int LW = 3;
  localparam int TOTAL = (P + 1) * (N + 3) - P * (P + 1) / 2;  // last busy cycle

  logic clk = 1'b0;
  logic reset, start, abort;
  logic busy, done, rd_en, mac_clear, r_valid;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic signed [15:0] rd_data_a = 16'sd0, rd_data_b = 16'sd0;
  logic signed [15:0] mac_x, mac_x_lag;
  logic signed [31:0] mac_y, r_data, acc, prod;
  logic [LW-1:0] r_lag;
  logic signed [15:0] mem [0:15];

  int n_checks = 0, n_err = 0;
  bit active = 0;
  int cyc = 0;
  int rv_cyc[$], rv_lag[$], rv_data[$], rden_q[$];
  int done_cyc = -1, rden_run = 0;

  autocorrelation_ctrl #(.FRAME_LEN(N), .ORDER(P), .ADDR_W(AW), .LAG_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_en(rd_en),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .mac_clear(mac_clear),
    .mac_x(mac_x), .mac_x_lag(mac_x_lag), .mac_y(mac_y),
    .r_data(r_data), .r_lag(r_lag), .r_valid(r_valid));

  always #5 clk = ~clk;

  // Frame buffer: one-cycle read latency on both ports
  always @(posedge clk) if (rd_en) begin
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
  end

  // MAC: synchronous clear, result is the accumulator's next value
  assign prod  = mac_x * mac_x_lag;
  assign mac_y = mac_clear ? 32'sd0 : acc + prod;
  always @(posedge clk) acc <= mac_clear ? 32'sd0 : acc + prod;

  function automatic int ref_r(int k);
    int s = 0;
    for (int n = k; n < N; n++) s += int'(mem[n]) * int'(mem[n - k]);
    return s;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  // Reference run tracker: cycle 0 is the cycle right after the start edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      cyc    <= 0;
    end else if (active && cyc <= TOTAL) begin
      if (abort) active <= 1'b0;
      else       cyc <= cyc + 1;
    end else if (start) begin
      active <= 1'b1;
      cyc    <= 0;
    end else if (active) begin
      cyc <= cyc + 1;
    end
  end

  // Compare process: expectations from the per-lag schedule of clear/issue/drain
  always @(negedge clk) begin : cmp
    int c, b, len, n;
    int e_busy, e_done, e_rdv, e_rden, e_a, e_b, e_clr, e_x, e_xl, e_lag, e_data;
    if (reset) begin
      e_busy = 0; e_done = 0; e_rdv = 0; e_rden = 0; e_a = 0; e_b = 0;
      e_clr = 1; e_x = 0; e_xl = 0; e_lag = 0; e_data = 0;
      if (active) begin
        c = cyc; b = 0;
        e_busy = (c <= TOTAL) ? 1 : 0;
        e_done = (c == TOTAL + 1) ? 1 : 0;
        for (int k = 0; k <= P; k++) begin
          len = N - k;
          if (c >= b + 1 && c <= b + len) begin
            e_rden = 1; e_a = k + (c - b - 1); e_b = c - b - 1;
          end
          if (c >= b + 1 && c <= b + len + 2) e_clr = 0;
          if (c - 2 >= b + 1 && c - 2 <= b + len) begin
            n = k + (c - b - 3);
            e_x = int'(mem[n]); e_xl = int'(mem[n - k]);
          end
          if (c == b + len + 3) begin
            e_rdv = 1; e_lag = k; e_data = ref_r(k);
          end
          b += len + 3;
        end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("rd_en", rd_en, e_rden);
      chk("rd_addr_a", rd_addr_a, e_a);
      chk("rd_addr_b", rd_addr_b, e_b);
      chk("mac_clear", mac_clear, e_clr);
      chk("mac_x", mac_x, e_x);
      chk("mac_x_lag", mac_x_lag, e_xl);
      chk("r_valid", r_valid, e_rdv);
      if (e_rdv == 1) begin
        chk("r_lag", r_lag, e_lag);
        chk("r_data", r_data, e_data);
      end
      if (active && rd_en) rden_run++;
      if (active && r_valid) begin
        rv_cyc.push_back(cyc); rv_lag.push_back(int'(r_lag));
        rv_data.push_back(int'(r_data)); rden_q.push_back(rden_run);
        rden_run = 0;
      end
      if (active && done) done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_rec();
    rv_cyc.delete(); rv_lag.delete(); rv_data.delete(); rden_q.delete();
    done_cyc = -1; rden_run = 0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_to(int t);
    for (int i = 0; i < 200 && cyc < t; i++) step();
    chk("run_to_cycle", cyc, t);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 200 && active && cyc <= TOTAL + 1; i++) step();
    chk("run_ended", (!active || cyc > TOTAL + 1), 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_r_valid", r_valid, 0); chk("rst_rd_en", rd_en, 0);
    chk("rst_addr_a", rd_addr_a, 0); chk("rst_addr_b", rd_addr_b, 0);
    chk("rst_mac_x", mac_x, 0);     chk("rst_mac_x_lag", mac_x_lag, 0);
    chk("rst_mac_clear", mac_clear, 1);
    chk("rst_r_data", r_data, 0);   chk("rst_r_lag", r_lag, 0);
  endtask

  // Timing pinned by hand: r_valid at 11/21/30, done at 31, reads 8/7/6
  task automatic check_run(bit lit, int d0, int d1, int d2);
    int ed[3];
    ed[0] = lit ? d0 : ref_r(0);
    ed[1] = lit ? d1 : ref_r(1);
    ed[2] = lit ? d2 : ref_r(2);
    chk("num_results", rv_cyc.size(), 3);
    if (rv_cyc.size() == 3) begin
      chk("rv_cycle0", rv_cyc[0], 11); chk("rv_cycle1", rv_cyc[1], 21);
      chk("rv_cycle2", rv_cyc[2], 30);
      for (int k = 0; k < 3; k++) begin
        chk("rv_lag_seq", rv_lag[k], k);
        chk("rv_data_seq", rv_data[k], ed[k]);
        chk("rd_en_count", rden_q[k], N - k);
      end
    end
    chk("done_cycle", done_cyc, 31);
  endtask

  task automatic fill(int v);
    for (int i = 0; i < 16; i++) mem[i] = 16'(v);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    fill(0);
    #12;
    check_reset_vals();
    @(posedge clk); #2 reset = 1'b1;
    step();

    // All zeros
    clear_rec(); do_start(); wait_end();
    check_run(1, 0, 0, 0);

    // Constant 1000: 8, 7, 6 products of 1000000
    fill(1000);
    chk("model_r0", ref_r(0), 8000000);
    chk("model_r2", ref_r(2), 6000000);
    clear_rec(); do_start(); wait_end();
    check_run(1, 8000000, 7000000, 6000000);

    // Random frames with random idle gaps
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 16'($signed($urandom_range(0, 16382)) - 8191);
      repeat ($urandom_range(0, 5)) step();
      clear_rec(); do_start(); wait_end();
      check_run(0, 0, 0, 0);
    end

    // start during lag-1 ISSUE is ignored
    clear_rec(); do_start(); run_to(15);
    start = 1'b1; step(); start = 1'b0;
    wait_end();
    check_run(0, 0, 0, 0);

    // abort during lag-1 ISSUE
    clear_rec(); do_start(); run_to(14);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mac_clear", mac_clear, 1);
    repeat (40) step();
    chk("abort_results", rv_cyc.size(), 1);
    chk("abort_no_done", done_cyc, -1);
    clear_rec(); do_start(); wait_end();
    check_run(0, 0, 0, 0);

    // Async reset during lag-1 DRAIN
    fill(1000);
    clear_rec(); do_start(); run_to(19);
    reset = 1'b0; #1;
    check_reset_vals();
    step(); step(); reset = 1'b1;
    repeat (3) step();
    chk("post_reset_no_results", rv_cyc.size(), 1);
    clear_rec(); do_start(); wait_end();
    check_run(1, 8000000, 7000000, 6000000);

    // Back-to-back: second start in the cycle after done
    for (int i = 0; i < N; i++) mem[i] = 16'($signed($urandom_range(0, 16382)) - 8191);
    clear_rec(); do_start(); run_to(TOTAL + 2);
    check_run(0, 0, 0, 0);
    clear_rec(); do_start(); wait_end();
    check_run(0, 0, 0, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
